// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg -- shared definitions for the iterative 32-bit divider.
//   XLEN          datapath width
//   F3_*          M-extension FUNCT3 codes for DIV/DIVU/REM/REMU
//   div_state_t   controller state encoding (IDLE, CALC, FIX)
//   helpers       op normalisation and op-class decode
// ---------------------------------------------------------------------------
package div_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   // Unknown codes collapse to DIVU so later decode only sees the four legal ops.
   function automatic logic [2:0] normalize_op(input logic [2:0] f3);
      logic [2:0] op;
      case (f3)
         F3_DIV:  op = F3_DIV;
         F3_DIVU: op = F3_DIVU;
         F3_REM:  op = F3_REM;
         F3_REMU: op = F3_REMU;
         default: op = F3_DIVU;
      endcase
      return op;
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == F3_DIV) || (op == F3_REM);
   endfunction

   function automatic logic op_is_rem(input logic [2:0] op);
      return (op == F3_REM) || (op == F3_REMU);
   endfunction

endpackage

// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if -- request/response bundle between the EX stage and the divider.
//   start, funct3, data1, data2, flush : requester -> divider
//   busy, done, result                 : divider -> requester
// ---------------------------------------------------------------------------
interface div_if;
   import div_pkg::*;

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, data1, data2, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, data1, data2, flush,
      output busy, done, result
   );

endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step -- one restoring shift-subtract iteration (purely combinational).
//   rem_in        partial remainder before the step
//   divisor       divisor magnitude
//   dividend_bit  next dividend bit, MSB first
//   rem_out       partial remainder after the step
//   quo_bit       quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_step
   import div_pkg::*;
(
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] divisor,
   input  logic            dividend_bit,
   output logic [XLEN-1:0] rem_out,
   output logic            quo_bit
);

   logic [XLEN:0]   shifted_s;
   logic            borrow_s;
   logic [XLEN-1:0] diff_s;

   // Shift, compare on 33 bits, and restore when the subtract would borrow.
   always_comb begin
      shifted_s = {rem_in, dividend_bit};
      borrow_s  = (shifted_s < {1'b0, divisor});
      // When no borrow occurs the true difference is below the divisor, so the
      // low 32 bits of the wrapped subtract are exact.
      diff_s    = shifted_s[XLEN-1:0] - divisor;
      if (borrow_s) begin
         rem_out = shifted_s[XLEN-1:0];
         quo_bit = 1'b0;
      end else begin
         rem_out = diff_s;
         quo_bit = 1'b1;
      end
   end

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- 32-bit iterative divider for DIV/DIVU/REM/REMU.
//   clk    clock, rising edge
//   reset  synchronous active-low reset
//   bus    div_if.slave: start/funct3/data1/data2/flush in,
//          busy/done/result out
// Normal ops take 32 CALC steps plus one FIX step; divide-by-zero and the
// signed overflow case answer directly from IDLE.
// ---------------------------------------------------------------------------
module div_unit
   import div_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   div_if.slave  bus
);

   div_state_t      state_r;
   logic [4:0]      count_r;
   logic [2:0]      op_r;
   logic [XLEN-1:0] dividend_r;
   logic [XLEN-1:0] divisor_r;
   logic [XLEN-1:0] rem_r;
   logic [XLEN-1:0] quo_r;
   logic            neg_quo_r;
   logic            neg_rem_r;
   logic            done_r;
   logic [XLEN-1:0] result_r;

   logic [2:0]      op_s;
   logic            sgn_s;
   logic            a_neg_s;
   logic            b_neg_s;
   logic [XLEN-1:0] a_mag_s;
   logic [XLEN-1:0] b_mag_s;
   logic            bypass_s;
   logic [XLEN-1:0] bypass_val_s;
   logic [XLEN-1:0] fix_val_s;
   logic [XLEN-1:0] step_rem_s;
   logic            step_quo_s;

   // Decode the incoming request: magnitudes, signs and the short-cut cases.
   always_comb begin
      op_s    = normalize_op(bus.funct3);
      sgn_s   = op_is_signed(op_s);
      a_neg_s = sgn_s & bus.data1[XLEN-1];
      b_neg_s = sgn_s & bus.data2[XLEN-1];
      // Negating 0x80000000 yields 0x80000000, read as unsigned 2^31.
      a_mag_s = a_neg_s ? (32'd0 - bus.data1) : bus.data1;
      b_mag_s = b_neg_s ? (32'd0 - bus.data2) : bus.data2;
      if (bus.data2 == 32'h0000_0000) begin
         bypass_s     = 1'b1;
         bypass_val_s = op_is_rem(op_s) ? bus.data1 : 32'hFFFF_FFFF;
      end else if (sgn_s && (bus.data1 == 32'h8000_0000) && (bus.data2 == 32'hFFFF_FFFF)) begin
         bypass_s     = 1'b1;
         bypass_val_s = op_is_rem(op_s) ? 32'h0000_0000 : 32'h8000_0000;
      end else begin
         bypass_s     = 1'b0;
         bypass_val_s = 32'h0000_0000;
      end
   end

   // Final sign correction applied on the FIX edge.
   always_comb begin
      if (op_is_rem(op_r)) begin
         fix_val_s = neg_rem_r ? (32'd0 - rem_r) : rem_r;
      end else begin
         fix_val_s = neg_quo_r ? (32'd0 - quo_r) : quo_r;
      end
   end

   div_step u_step (
      .rem_in       (rem_r),
      .divisor      (divisor_r),
      .dividend_bit (dividend_r[XLEN-1]),
      .rem_out      (step_rem_s),
      .quo_bit      (step_quo_s)
   );

   // Controller and datapath registers; reset beats flush, flush beats start.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         count_r    <= 5'd0;
         op_r       <= 3'd0;
         dividend_r <= 32'h0000_0000;
         divisor_r  <= 32'h0000_0000;
         rem_r      <= 32'h0000_0000;
         quo_r      <= 32'h0000_0000;
         neg_quo_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         done_r     <= 1'b0;
         result_r   <= 32'h0000_0000;
      end else begin
         done_r <= 1'b0;
         if (bus.flush) begin
            state_r <= IDLE;
            count_r <= 5'd0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (bus.start) begin
                     op_r       <= op_s;
                     dividend_r <= a_mag_s;
                     divisor_r  <= b_mag_s;
                     neg_quo_r  <= a_neg_s ^ b_neg_s;
                     neg_rem_r  <= a_neg_s;
                     rem_r      <= 32'h0000_0000;
                     quo_r      <= 32'h0000_0000;
                     count_r    <= 5'd0;
                     if (bypass_s) begin
                        result_r <= bypass_val_s;
                        done_r   <= 1'b1;
                     end else begin
                        state_r <= CALC;
                     end
                  end else begin
                     state_r <= IDLE;
                  end
               end
               CALC: begin
                  rem_r      <= step_rem_s;
                  quo_r      <= {quo_r[XLEN-2:0], step_quo_s};
                  dividend_r <= {dividend_r[XLEN-2:0], 1'b0};
                  count_r    <= count_r + 5'd1;
                  // 32nd step: counter wraps to zero as we leave.
                  if (count_r == 5'd31) begin
                     state_r <= FIX;
                  end else begin
                     state_r <= CALC;
                  end
               end
               FIX: begin
                  result_r <= fix_val_s;
                  done_r   <= 1'b1;
                  state_r  <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy   = (state_r != IDLE);
   assign bus.done   = done_r;
   assign bus.result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// A cycle-level reference (remaining-latency counter plus arithmetic result)
// is compared against busy/done/result on every falling edge; directed cases
// pin literal results and latencies; a random phase exercises all ops.
// ---------------------------------------------------------------------------
module tb_div_unit;

   logic clk;
   logic reset;
   div_if bus ();

   div_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;
   bit chk_en;

   // Reference model state.
   logic        m_busy;
   logic        m_done;
   logic [31:0] m_result;
   logic [31:0] m_pending;
   int          m_left;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit f3_signed(input logic [2:0] f3);
      return (f3 == 3'b100) || (f3 == 3'b110);
   endfunction

   function automatic bit f3_rem(input logic [2:0] f3);
      return (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Architectural result from plain 64-bit arithmetic (truncating division).
   function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return f3_rem(f3) ? a : 32'hFFFF_FFFF;
      if (f3_signed(f3)) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return f3_rem(f3) ? r[31:0] : q[31:0];
   endfunction

   function automatic bit ref_bypass(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (f3_signed(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Cycle model: an accepted op answers after 1 cycle (bypass) or 34 cycles.
   always @(posedge clk) begin
      m_done <= 1'b0;
      if (!reset) begin
         m_busy   <= 1'b0;
         m_left   <= 0;
         m_result <= 32'd0;
      end else if (bus.flush) begin
         m_busy <= 1'b0;
         m_left <= 0;
      end else if (!m_busy) begin
         if (bus.start) begin
            if (ref_bypass(bus.funct3, bus.data1, bus.data2)) begin
               m_result <= ref_div(bus.funct3, bus.data1, bus.data2);
               m_done   <= 1'b1;
            end else begin
               m_busy    <= 1'b1;
               m_left    <= 33;
               m_pending <= ref_div(bus.funct3, bus.data1, bus.data2);
            end
         end
      end else if (m_left == 1) begin
         m_busy   <= 1'b0;
         m_left   <= 0;
         m_done   <= 1'b1;
         m_result <= m_pending;
      end else begin
         m_left <= m_left - 1;
      end
   end

   // Compare DUT outputs to the model every cycle once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
         check("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
         check("cyc_result", bus.result, m_result);
      end
   end

   // Present a request for one cycle; afterwards operands are scrambled.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.funct3 = f3;
      bus.data1  = a;
      bus.data2  = b;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.data1  = $urandom;
      bus.data2  = $urandom;
      bus.funct3 = 3'($urandom_range(0, 7));
   endtask

   // Called right after issue(): n = cycles from the START cycle to DONE.
   task automatic wait_done(output int n, output int busy_cnt);
      n = 1;
      busy_cnt = int'(bus.busy);
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
         busy_cnt += int'(bus.busy);
      end
   endtask

   task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int n;
      int bc;
      issue(f3, a, b);
      wait_done(n, bc);
      check({nm, "_lat"}, 32'(n), 32'(exp_lat));
      check({nm, "_res"}, bus.result, exp);
   endtask

   initial begin
      int n;
      int bc;
      int seen;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      n_pass = 0;
      n_total = 0;
      chk_en = 1'b0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.funct3 = 3'd0;
      bus.data1 = 32'd0;
      bus.data2 = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      chk_en = 1'b1;
      reset = 1'b1;
      @(negedge clk);

      // Pin the reference model itself.
      check("model_div", ref_div(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("model_rem", ref_div(3'b110, 32'd7, 32'hFFFF_FFFE), 32'd1);
      check("model_ovf", ref_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

      // DIVU 100/7: 33 busy cycles, DONE in the 34th cycle.
      issue(3'b101, 32'd100, 32'd7);
      wait_done(n, bc);
      check("divu_lat", 32'(n), 32'd34);
      check("divu_busy_cycles", 32'(bc), 32'd33);
      check("divu_res", bus.result, 32'd14);
      // Back-to-back: start issued in the DONE cycle.
      run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
      run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("div_negb", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      run_op("rem_negb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
      run_op("bad_f3", 3'b000, 32'd100, 32'd7, 32'd14, 34);

      // Bypass cases: DONE next cycle, BUSY never asserted.
      issue(3'b100, 32'd5, 32'd0);
      wait_done(n, bc);
      check("dz_lat", 32'(n), 32'd1);
      check("dz_busy", 32'(bc), 32'd0);
      check("dz_res", bus.result, 32'hFFFF_FFFF);
      run_op("rem_dz", 3'b110, 32'd5, 32'd0, 32'd5, 1);
      run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n, bc);
      check("rem_ovf_res", bus.result, 32'd0);
      check("rem_ovf_busy", 32'(bc), 32'd0);
      run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
      @(negedge clk);

      // Flush around CALC iteration 10.
      issue(3'b101, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_done", {31'd0, bus.done}, 32'd0);
      check("flush_result", bus.result, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         seen += int'(bus.done);
      end
      check("flush_no_done", 32'(seen), 32'd0);
      run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 34);

      // START while busy is ignored; START in DONE cycle is accepted.
      issue(3'b101, 32'd50, 32'd5);
      repeat (4) @(negedge clk);
      bus.funct3 = 3'b101;
      bus.data1 = 32'd99;
      bus.data2 = 32'd9;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 6;
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ignore_lat", 32'(n), 32'd34);
      check("ignore_res", bus.result, 32'd10);
      run_op("b2b", 3'b101, 32'd77, 32'd7, 32'd11, 34);

      // Reset mid-CALC.
      issue(3'b101, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_done", {31'd0, bus.done}, 32'd0);
      check("midrst_result", bus.result, 32'd0);

      // FLUSH and START together in IDLE: nothing starts.
      bus.funct3 = 3'b101;
      bus.data1 = 32'd10;
      bus.data2 = 32'd2;
      bus.start = 1'b1;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("fs_busy", {31'd0, bus.busy}, 32'd0);
      check("fs_done", {31'd0, bus.done}, 32'd0);
      repeat (3) @(negedge clk);

      // Random operations, occasionally flushed.
      for (int i = 0; i < 250; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            3: b = 32'($urandom_range(1, 5)) ^ {32{b[31]}};
            default: ;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            issue(f3, a, b);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
         end else begin
            run_op("rand", f3, a, b, ref_div(f3, a, b), ref_bypass(f3, a, b) ? 1 : 34);
         end
      end
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
